spike_event_encoder: RTL and testbench
======================================

Name: spike_event_encoder

Overview:
- Sits on the write-back side of the time-multiplexed neuron array. It consumes the per-neuron state stream the array emits, one neuron per cycle.
- Detects upward threshold crossings of membrane voltage and emits address events {timestep, neuron_id} on a valid/ready output buffered by a small FIFO.
- Downstream consumer is a spike router/host readout. The input side can never stall, so overflow is dropped and counted.

Parameters:
- NEURON_COUNT, 500, neurons per TDM frame; ids 0..NEURON_COUNT-1
- DATA_WIDTH, 16, signed membrane voltage width, Q4.12 (16'h1000 = 1.0 V)
- TS_WIDTH, 16, timestep (frame) counter width
- FIFO_DEPTH, 16, event FIFO entries, power of two, minimum 2
- DROP_WIDTH, 16, dropped-event counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  state sample present this cycle
- in_id  in  $clog2(NEURON_COUNT)  neuron index of sample
- in_v  in  DATA_WIDTH signed  updated membrane voltage
- thr  in  DATA_WIDTH signed  spike threshold, sampled each cycle
- enable  in  1  event generation enable
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event
- ev_id  out  $clog2(NEURON_COUNT)  spiking neuron index
- ev_ts  out  TS_WIDTH  timestep of the spike
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: at least one event dropped
- drop_count  out  DROP_WIDTH  dropped events, saturating

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: ev_valid=0, ev_id=0, ev_ts=0, fifo_level=0, overflow=0, drop_count=0. All above-threshold flags and the timestep counter are cleared. FIFO contents are discarded.
- Input has no backpressure. A sample is taken on every edge where in_valid=1.
- Stage 1 (edge N): register in_valid, in_id, in_v, thr, and enable.
- Stage 2 (edge N+1):
  - above = (v_r >= thr_r), signed compare.
  - spike = valid_r & enable_r & above & ~flag[id_r].
  - flag[id_r] <= above. Flags update even when enable=0, so enabling never produces a stale burst.
- Latency: a sample at edge N whose spike enters an empty FIFO gives ev_valid=1 after edge N+1 (2 edges).
- Flag read and write happen in the same stage, so back-to-back samples of the same id (NEURON_COUNT=1) need no forwarding.
- Out-of-range id_r (>= NEURON_COUNT): sample ignored, no flag write, no event, no timestep effect.
- Timestep:
  - ts counter increments after stage 2 processes a valid sample with id_r == NEURON_COUNT-1.
  - Wraps modulo 2^TS_WIDTH.
  - An event carries the ts value before that increment, i.e. the frame the spike belongs to.
- FIFO: first-word-fall-through. ev_id and ev_ts are the head entry and stay stable while ev_valid & ~ev_ready.
  - Pop when ev_valid & ev_ready.
  - Push when spike and (not full, or pop this cycle). A simultaneous push and pop when full is accepted and the level is unchanged.
  - Push when full with no pop: event dropped, overflow<=1, drop_count increments and saturates at all-ones.
  - Simultaneous push and pop when empty: pushed entry appears next cycle. ev_valid stays 0 this cycle, so there is no bypass.
- fifo_level is registered and exact after every edge.
- Reset mid-operation: the in-flight stage-1 sample is discarded, queued events are lost, and the next frame starts at ts=0.

Decomposition:
- Shared package snn_pkg holds:
  - DATA_WIDTH and the Q4.12 constants V_ONE=16'h1000, V_REST=16'hECE1, W_REST=16'hF600
  - default NEURON_COUNT
  - the event field widths: id width via $clog2(NEURON_COUNT), TS_WIDTH
- One sub-module, event_fifo: parameterised FWFT synchronous FIFO with push, pop, full, empty, and level; data = {ts, id}.
- Detection, flag vector, timestep, and drop logic stay in the top level.

Test Plan:
- Single crossing:
  - Stimulus: thr=16'h1000, ev_ready=1, enable=1. Stream ids 0..499 with v=16'hECE1, except id 7 with v=16'h1200 in frame 0.
  - Response: exactly one event, id=7, ts=0. ev_valid rises 2 edges after the id-7 sample.
- No re-trigger:
  - Stimulus: id 7 stays at v=16'h1200 in frames 1-3, then 16'h0800 in frame 4, then 16'h1000 in frame 5.
  - Response: no events in frames 1-4; one event id=7, ts=5 (equality counts as above).
- Enable gating:
  - Stimulus: enable=0 while id 3 crosses in frame 0; enable=1 and id 3 stays high in frame 1.
  - Response: zero events.
- Backpressure and overflow:
  - Stimulus: ev_ready=0, 20 neurons cross in one frame, FIFO_DEPTH=16.
  - Response: fifo_level=16, overflow=1, drop_count=4. Releasing ready drains 16 events in id order with ts=0.
- Full with push and pop: FIFO full, ev_ready=1 on the same cycle a new spike arrives -> push accepted, level stays 16, drop_count unchanged.
- Reset mid-frame:
  - Stimulus: assert rst at id 250 of frame 3 with 5 events queued.
  - Response: all outputs 0 after the edge. The next crossing at id 0 reports ts=0. An out-of-range id 510 produces nothing.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants for the spiking-neuron array: voltage format and event field widths.
package snn_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int NEURON_COUNT_DEF = 500;
    localparam int TS_WIDTH_DEF     = 16;
    localparam int ID_WIDTH_DEF     = $clog2(NEURON_COUNT_DEF);

    // Q4.12 reference voltages
    localparam logic signed [DATA_WIDTH_DEF-1:0] V_ONE  = 16'h1000;
    localparam logic signed [DATA_WIDTH_DEF-1:0] V_REST = 16'hECE1;
    localparam logic signed [DATA_WIDTH_DEF-1:0] W_REST = 16'hF600;

endpackage

// File: rtl/spike_event_encoder_if.sv
// Neuron state stream in, address events out (valid/ready).
interface spike_event_encoder_if #(
    parameter int ID_W   = 9,
    parameter int DATA_W = 16,
    parameter int TS_W   = 16
);
    logic                     in_valid;
    logic [ID_W-1:0]          in_id;
    logic signed [DATA_W-1:0] in_v;
    logic                     ev_valid;
    logic                     ev_ready;
    logic [ID_W-1:0]          ev_id;
    logic [TS_W-1:0]          ev_ts;

    modport master (output in_valid, in_id, in_v, ev_ready,
                    input  ev_valid, ev_id, ev_ts);
    modport slave  (input  in_valid, in_id, in_v, ev_ready,
                    output ev_valid, ev_id, ev_ts);
endinterface

// File: rtl/spike_event_encoder_fifo.sv
// First-word-fall-through synchronous FIFO holding {ts, id} events.
module event_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head is masked while empty so the outputs read zero after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/spike_event_encoder.sv
// Upward threshold-crossing detector for the TDM neuron stream; emits {timestep, id} events.
module spike_event_encoder
    import snn_pkg::*;
#(
    parameter int NEURON_COUNT = NEURON_COUNT_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int TS_WIDTH     = TS_WIDTH_DEF,
    parameter int FIFO_DEPTH   = 16,
    parameter int DROP_WIDTH   = 16,
    localparam int ID_W        = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    spike_event_encoder_if.slave         bus,
    input  logic signed [DATA_WIDTH-1:0] thr,
    input  logic                         enable,
    output logic [LVL_W-1:0]             fifo_level,
    output logic                         overflow,
    output logic [DROP_WIDTH-1:0]        drop_count
);
    logic                         valid_r, enable_r;
    logic [ID_W-1:0]              id_r;
    logic signed [DATA_WIDTH-1:0] v_r, thr_r;
    logic [NEURON_COUNT-1:0]      flag;
    logic [TS_WIDTH-1:0]          ts;

    logic in_range, hit, above, flag_rd, spike, frame_end;
    logic pop, push, drop, full, empty;
    logic [TS_WIDTH+ID_W-1:0] head;

    // Stage 1: capture the sample as presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= 1'b0;
            enable_r <= 1'b0;
            id_r     <= '0;
            v_r      <= '0;
            thr_r    <= '0;
        end else begin
            valid_r  <= bus.in_valid;
            enable_r <= enable;
            id_r     <= bus.in_id;
            v_r      <= bus.in_v;
            thr_r    <= thr;
        end
    end

    // Stage 2: flag read and write in the same cycle, so no forwarding is needed.
    assign in_range  = (int'(id_r) < NEURON_COUNT);
    assign hit       = valid_r & in_range;
    assign above     = (v_r >= thr_r);
    assign flag_rd   = in_range ? flag[id_r] : 1'b0;
    assign spike     = hit & enable_r & above & ~flag_rd;
    assign frame_end = hit & (int'(id_r) == NEURON_COUNT - 1);

    assign pop  = bus.ev_valid & bus.ev_ready;
    assign push = spike & (~full | pop);
    assign drop = spike & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag       <= '0;
            ts         <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            // Flags track the level even while disabled, so enabling never bursts.
            if (hit) flag[id_r] <= above;
            if (frame_end) ts <= ts + TS_WIDTH'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (~&drop_count) drop_count <= drop_count + DROP_WIDTH'(1);
            end
        end
    end

    event_fifo #(
        .WIDTH (TS_WIDTH + ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({ts, id_r}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign bus.ev_valid = ~empty;
    assign {bus.ev_ts, bus.ev_id} = head;
endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: detection, gating, latency, overflow, reset.
module tb_spike_event_encoder;
    import snn_pkg::*;

    localparam int NC = 500;
    localparam int IW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] thr = 16'h1000;
    logic enable = 1'b1;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;
    int qb = 0;
    logic [15:0] vt [NC];
    logic [IW+15:0] evq [$];

    always #5 clk = ~clk;

    spike_event_encoder_if #(.ID_W(IW), .DATA_W(16), .TS_W(16)) bus ();

    spike_event_encoder #(
        .NEURON_COUNT (NC),
        .DATA_WIDTH   (16),
        .TS_WIDTH     (16),
        .FIFO_DEPTH   (16),
        .DROP_WIDTH   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .thr        (thr),
        .enable     (enable),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    // Log every accepted event {ts, id}; handshake inputs are stable at the falling edge.
    always @(negedge clk)
        if (!rst && bus.ev_valid && bus.ev_ready) evq.push_back({bus.ev_ts, bus.ev_id});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vld, input int id, input logic [15:0] v);
        bus.in_valid = vld;
        bus.in_id    = IW'(id);
        bus.in_v     = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, V_REST);
    endtask

    task automatic stream(input int a, input int b);
        for (int i = a; i <= b; i++) step(1'b1, i, vt[i]);
    endtask

    task automatic rest_all();
        for (int i = 0; i < NC; i++) vt[i] = V_REST;
    endtask

    initial begin
        bus.ev_ready = 1'b1;
        rest_all();
        idle(2);
        chk("rst_ev_valid", 32'(bus.ev_valid), 0);
        chk("rst_ev_id", 32'(bus.ev_id), 0);
        chk("rst_ev_ts", 32'(bus.ev_ts), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_count), 0);
        rst = 1'b0;

        // Frame 0: id 7 crosses; event appears two edges after its sample.
        vt[7] = 16'h1200;
        stream(0, 6);
        stream(7, 7);
        chk("lat_after_n", 32'(bus.ev_valid), 0);
        stream(8, 8);
        chk("lat_after_n1", 32'(bus.ev_valid), 1);
        chk("single_id", 32'(bus.ev_id), 7);
        chk("single_ts", 32'(bus.ev_ts), 0);
        stream(9, NC - 1);
        idle(3);
        chk("single_count", 32'(evq.size() - qb), 1);
        qb = evq.size();

        // Frames 1-3 stay high, frame 4 drops below: no re-trigger.
        for (int f = 1; f <= 4; f++) begin
            vt[7] = (f == 4) ? 16'h0800 : 16'h1200;
            stream(0, NC - 1);
        end
        idle(3);
        chk("noretrig_count", 32'(evq.size() - qb), 0);
        // Frame 5: equality counts as above.
        vt[7] = 16'h1000;
        stream(0, NC - 1);
        idle(3);
        chk("eq_count", 32'(evq.size() - qb), 1);
        if (evq.size() > qb) chk("eq_event", 32'(evq[qb]), {16'd5, 9'd7});
        qb = evq.size();

        // Crossing while disabled, then held high once enabled: nothing.
        vt[7] = V_REST;
        vt[3] = 16'h1200;
        enable = 1'b0;
        stream(0, NC - 1);
        enable = 1'b1;
        stream(0, NC - 1);
        idle(3);
        chk("gate_count", 32'(evq.size() - qb), 0);

        // Fresh epoch; 20 crossings into a 16-deep FIFO with no ready.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus.ev_ready = 1'b0;
        rest_all();
        for (int i = 100; i < 120; i++) vt[i] = 16'h1200;
        qb = evq.size();
        stream(0, NC - 1);
        idle(3);
        chk("ovf_level", 32'(fifo_level), 16);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop", 32'(drop_count), 4);
        chk("ovf_head_id", 32'(bus.ev_id), 100);
        chk("ovf_head_ts", 32'(bus.ev_ts), 0);

        // Full FIFO: pop and push on the same edge keeps level and drop count.
        vt[200] = 16'h1200;
        stream(0, 200);
        bus.ev_ready = 1'b1;
        stream(201, 201);
        bus.ev_ready = 1'b0;
        chk("pp_level", 32'(fifo_level), 16);
        chk("pp_drop", 32'(drop_count), 4);
        chk("pp_head_id", 32'(bus.ev_id), 101);
        stream(202, NC - 1);
        idle(3);
        bus.ev_ready = 1'b1;
        idle(20);
        chk("drain_count", 32'(evq.size() - qb), 17);
        for (int k = 0; k < 17 && qb + k < evq.size(); k++)
            chk($sformatf("drain_%0d", k), 32'(evq[qb + k]),
                (k < 16) ? {16'd0, IW'(100 + k)} : {16'd1, 9'd200});
        chk("drain_level", 32'(fifo_level), 0);

        // Reset mid-frame with 5 events queued and overflow still set.
        bus.ev_ready = 1'b0;
        rest_all();
        for (int i = 10; i < 15; i++) vt[i] = 16'h1200;
        vt[249] = 16'h1200;
        stream(0, 249);
        chk("mid_level", 32'(fifo_level), 5);
        rst = 1'b1;
        step(1'b1, 250, 16'h1200);
        rst = 1'b0;
        chk("mrst_ev_valid", 32'(bus.ev_valid), 0);
        chk("mrst_ev_id", 32'(bus.ev_id), 0);
        chk("mrst_ev_ts", 32'(bus.ev_ts), 0);
        chk("mrst_level", 32'(fifo_level), 0);
        chk("mrst_overflow", 32'(overflow), 0);
        chk("mrst_drop", 32'(drop_count), 0);
        qb = evq.size();
        bus.ev_ready = 1'b1;
        step(1'b1, 0, 16'h1200);
        idle(1);
        chk("post_valid", 32'(bus.ev_valid), 1);
        chk("post_id", 32'(bus.ev_id), 0);
        chk("post_ts", 32'(bus.ev_ts), 0);
        step(1'b1, 510, 16'h1200);
        idle(3);
        chk("oor_count", 32'(evq.size() - qb), 1);
        chk("oor_level", 32'(fifo_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
